// File: rtl/enc_framer_pkg.sv
`default_nettype none
// ============================================================================
// enc_framer_pkg - shared constants, FSM state and FIFO entry for enc_framer
// Revision 1.0
// ============================================================================
package enc_framer_pkg;

    localparam int ENC_SYM_NUM = 4;
    localparam int EGF_ORDER   = 8;
    localparam int RS_COD_LEN  = 255;

    localparam int DATA_W = ENC_SYM_NUM * EGF_ORDER;
    localparam int LANE_W = (ENC_SYM_NUM > 1) ? $clog2(ENC_SYM_NUM) : 1;
    localparam int POS_W  = $clog2(RS_COD_LEN);

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } frm_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic [LANE_W-1:0] sof_lane;
        logic              eof;
        logic [LANE_W-1:0] eof_lane;
    } frm_beat_t;

    localparam int BEAT_W = $bits(frm_beat_t);

    // (p + ENC_SYM_NUM) mod RS_COD_LEN; one subtract suffices since ENC_SYM_NUM <= RS_COD_LEN.
    function automatic logic [POS_W-1:0] pos_advance(input logic [POS_W-1:0] p);
        logic [POS_W:0] sum;
        sum = {1'b0, p} + (POS_W+1)'(ENC_SYM_NUM);
        if (sum >= (POS_W+1)'(RS_COD_LEN)) begin
            sum = sum - (POS_W+1)'(RS_COD_LEN);
        end
        return sum[POS_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_framer_fifo.sv
`default_nettype none
// ============================================================================
// frm_fifo - synchronous FIFO with full/empty flags; head reads as zero when empty
// Revision 1.0
// ============================================================================
module frm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/enc_framer.sv
`default_nettype none
// ============================================================================
// enc_framer - codeword alignment, SOF/EOF tagging and output buffering
// Revision 1.0
// ============================================================================
module enc_framer
    import enc_framer_pkg::*;
#(
    parameter int ENC_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] enc_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic [LANE_W-1:0] out_sof_lane,
    output logic              out_eof,
    output logic [LANE_W-1:0] out_eof_lane,
    output logic [15:0]       cw_count,
    output logic              overflow
);

    localparam int WARM_W = (ENC_LATENCY > 1) ? $clog2(ENC_LATENCY) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((ENC_LATENCY > 0) ? ENC_LATENCY - 1 : 0);
    localparam frm_state_t RESET_STATE = (ENC_LATENCY == 0) ? RUN : WARMUP;

    localparam logic [POS_W:0] LEN_X = (POS_W+1)'(RS_COD_LEN);
    localparam logic [POS_W:0] SYM_X = (POS_W+1)'(ENC_SYM_NUM);
    localparam logic [POS_W:0] ONE_X = (POS_W+1)'(1);

    frm_state_t        state;
    frm_state_t        state_next;
    logic              run;
    logic [WARM_W-1:0] warm_cnt;
    logic [POS_W-1:0]  pos;
    logic [POS_W:0]    pos_x;
    logic [POS_W:0]    sof_diff;
    logic [POS_W:0]    eof_diff;
    logic              tag_sof;
    logic              tag_eof;
    frm_beat_t         beat_in;
    frm_beat_t         beat_head;
    logic [BEAT_W-1:0] head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        run        = 1'b0;
        case (state)
            WARMUP: begin
                if (warm_cnt == WARM_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
            end
            default: state_next = RESET_STATE;
        endcase
    end

    // Tags are derived from the codeword index of the earliest lane.
    assign pos_x    = {1'b0, pos};
    assign sof_diff = pos_x + SYM_X - ONE_X - LEN_X;
    assign eof_diff = pos_x + SYM_X - LEN_X;
    assign tag_sof  = (pos == '0) || (pos_x > (LEN_X - SYM_X));
    assign tag_eof  = (pos_x >= (LEN_X - SYM_X));

    always_comb begin
        beat_in          = '0;
        beat_in.data     = enc_in;
        beat_in.sof      = tag_sof;
        beat_in.eof      = tag_eof;
        if (pos == '0) begin
            beat_in.sof_lane = LANE_W'(ENC_SYM_NUM - 1);
        end else if (tag_sof) begin
            beat_in.sof_lane = sof_diff[LANE_W-1:0];
        end
        if (tag_eof) begin
            beat_in.eof_lane = eof_diff[LANE_W-1:0];
        end
    end

    assign pop  = out_valid && out_ready;
    assign drop = run && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_cnt <= '0;
            pos      <= '0;
            cw_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == WARMUP) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            if (run) begin
                pos <= pos_advance(pos);
                if (tag_eof) begin
                    cw_count <= cw_count + 16'd1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    frm_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (run),
        .wdata (beat_in),
        .pop   (pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign beat_head    = frm_beat_t'(head_bits);
    assign out_valid    = !fifo_empty;
    assign out_data     = beat_head.data;
    assign out_sof      = beat_head.sof;
    assign out_sof_lane = beat_head.sof_lane;
    assign out_eof      = beat_head.eof;
    assign out_eof_lane = beat_head.eof_lane;

endmodule
`default_nettype wire

// File: tb/tb_enc_framer.sv
`default_nettype none
// ============================================================================
// tb_enc_framer - randomized bench with a symbol-index reference model
// Revision 1.0
// ============================================================================
module tb_enc_framer;
    import enc_framer_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 8;
    localparam int SYM   = ENC_SYM_NUM;
    localparam int LEN   = RS_COD_LEN;
    localparam int DW    = ENC_SYM_NUM * EGF_ORDER;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     enc_in = '0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_sof;
    logic [LANE_W-1:0] out_sof_lane;
    logic              out_eof;
    logic [LANE_W-1:0] out_eof_lane;
    logic [15:0]       cw_count;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    enc_framer #(
        .ENC_LATENCY (LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enc_in       (enc_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_sof_lane (out_sof_lane),
        .out_eof      (out_eof),
        .out_eof_lane (out_eof_lane),
        .cw_count     (cw_count),
        .overflow     (overflow)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            sof;
        int            sof_lane;
        bit            eof;
        int            eof_lane;
    } mbeat_t;

    mbeat_t q[$];
    int     m_high = 0;
    int     m_cw   = 0;
    bit     m_ovf  = 0;

    // Beat k of a run starts at absolute symbol k*SYM; lane l holds symbol k*SYM+(SYM-1-l).
    function automatic mbeat_t make_beat(input int k, input logic [DW-1:0] d);
        mbeat_t b;
        int s;
        b.data = d; b.sof = 0; b.sof_lane = 0; b.eof = 0; b.eof_lane = 0;
        for (int l = 0; l < SYM; l++) begin
            s = (k * SYM + (SYM - 1 - l)) % LEN;
            if (s == 0)       begin b.sof = 1; b.sof_lane = l; end
            if (s == LEN - 1) begin b.eof = 1; b.eof_lane = l; end
        end
        return b;
    endfunction

    always @(posedge clk) begin
        int     pre;
        bit     popped;
        mbeat_t b;
        if (!rst_n) begin
            q.delete();
            m_high = 0;
            m_cw   = 0;
            m_ovf  = 0;
        end else begin
            pre    = q.size();
            popped = (pre > 0) && out_ready;
            if (popped) void'(q.pop_front());
            if (m_high >= LAT) begin
                b = make_beat(m_high - LAT, enc_in);
                if (b.eof) m_cw = (m_cw + 1) % 65536;
                if (pre < DEPTH || popped) q.push_back(b);
                else m_ovf = 1;
            end
            m_high++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_data",     64'(out_data),     64'(q[0].data));
                chk("out_sof",      64'(out_sof),      64'(q[0].sof));
                chk("out_sof_lane", 64'(out_sof_lane), 64'(q[0].sof_lane));
                chk("out_eof",      64'(out_eof),      64'(q[0].eof));
                chk("out_eof_lane", 64'(out_eof_lane), 64'(q[0].eof_lane));
            end else begin
                chk("empty_data", 64'(out_data), 64'(0));
                chk("empty_tags", 64'({out_sof, out_sof_lane, out_eof, out_eof_lane}), 64'(0));
            end
            chk("cw_count", 64'(cw_count), 64'(m_cw));
            chk("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        enc_in = DW'($urandom);
    endtask

    initial begin
        // Initial reset, then release with a free-flowing sink.
        step();
        started = 1;
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            step();
            @(negedge clk);
            case (n)
                3: chk("lit_valid_c3", 64'(out_valid), 64'(0));
                4: begin
                    chk("lit_valid_c4", 64'(out_valid), 64'(1));
                    chk("lit_sof_c4", 64'({out_sof, out_sof_lane, out_eof}), 64'({1'b1, 2'd3, 1'b0}));
                end
                67: chk("lit_beat63", 64'({out_sof, out_sof_lane, out_eof, out_eof_lane}),
                        64'({1'b1, 2'd0, 1'b1, 2'd1}));
                68: chk("lit_beat64", 64'({out_sof, out_eof}), 64'(0));
                259: begin
                    chk("lit_beat255", 64'({out_sof, out_sof_lane, out_eof}), 64'({1'b1, 2'd3, 1'b0}));
                    chk("lit_cw4", 64'(cw_count), 64'(4));
                end
                default: ;
            endcase
        end

        // Backpressure: FIFO fills and drops, then a random sink drains it.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        @(negedge clk);
        chk("lit_ovf_hold", 64'({out_valid, overflow}), 64'({1'b1, 1'b1}));
        for (int i = 0; i < 300; i++) begin
            step();
            out_ready = ($urandom % 4) != 0;
        end

        // One-cycle reset mid-stream with a non-empty FIFO.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("lit_rst_clear", 64'({out_valid, overflow, cw_count}), 64'(0));

        // Warmup again, fill to full, then push and pop together.
        for (int n = 1; n <= 13; n++) begin
            step();
            if (n == 11) out_ready = 1'b1;
            if (n == 12) out_ready = 1'b0;
            @(negedge clk);
            case (n)
                3: chk("lit2_valid_c3", 64'(out_valid), 64'(0));
                4: chk("lit2_sof_lane", 64'({out_valid, out_sof, out_sof_lane}), 64'({1'b1, 1'b1, 2'd3}));
                11: chk("lit2_full_no_ovf", 64'({out_valid, overflow}), 64'({1'b1, 1'b0}));
                12: chk("lit2_pushpop_no_ovf", 64'(overflow), 64'(0));
                13: chk("lit2_ovf_set", 64'(overflow), 64'(1));
                default: ;
            endcase
        end

        for (int i = 0; i < 300; i++) begin
            step();
            out_ready = ($urandom % 3) != 0;
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
